cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among NUM_REQ completing units: ALU, MULT, branch, LSQ.
- Each requester owns a one-entry holding buffer. Each cycle one occupied buffer is granted and its result is driven onto a registered CDB output stage.
- The CDB output feeds the ROB completion port and the RS wakeup logic.
- Squash flushes all in-flight results.

Parameters:
- NUM_REQ, 4, number of requesting units (index 0 = ALU ... NUM_REQ-1 = LSQ).
- TAG_W, 5, ROB tag width (clog2 of ROB size 32).
- DATA_W, 32, result value / PC width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- squash  in  1  branch-mispredict flush, synchronous.
- req_valid  in  NUM_REQ  unit i presents a result.
- req_tag  in  NUM_REQ*TAG_W  ROB tag per unit.
- req_value  in  NUM_REQ*DATA_W  result value per unit.
- req_pc  in  NUM_REQ*DATA_W  instruction PC per unit; the ROB uses it for its match check.
- req_take_branch  in  NUM_REQ  branch-taken flag per unit.
- rob_head  in  TAG_W  current ROB head index; used only with the optional feature.
- req_ready  out  NUM_REQ  buffer i can accept this cycle.
- cdb_valid  out  1  CDB carries a result.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_value  out  DATA_W  broadcast value.
- cdb_pc  out  DATA_W  broadcast PC.
- cdb_take_branch  out  1  broadcast branch flag.
- cdb_src  out  clog2(NUM_REQ)  index of the winning unit.
- pending_cnt  out  clog2(NUM_REQ)+1  number of occupied holding buffers.

Behaviour:
- Reset (async, active-high):
  - All buffer valid bits, cdb_valid and pending_cnt = 0.
  - cdb_tag, cdb_value, cdb_pc, cdb_take_branch, cdb_src = 0.
  - Round-robin pointer = 0.
  - req_ready = all 1s once reset deasserts.
- Handshake:
  - Transfer occurs when req_valid[i] && req_ready[i] at a rising edge; the payload is written into buffer i.
  - req_ready[i] = !buf_valid[i] || grant[i], so a granted buffer is refilled the same edge it drains.
  - req_ready[i] = 0 while squash is high.
  - A unit must hold its payload stable while req_valid && !req_ready.
- Arbitration:
  - Combinational over occupied buffers only; incoming requests are not bypassed.
  - Round-robin: search starts at the pointer and wraps modulo NUM_REQ; the first occupied buffer wins.
  - On a grant, pointer <= winner+1, wrapping NUM_REQ-1 -> 0. With no grant, the pointer holds.
- Output:
  - On a grant edge: cdb_* <= winner payload, cdb_src <= winner, cdb_valid <= 1.
  - With no grant: cdb_valid <= 0 and the payload fields hold their previous values.
  - cdb_valid is high for exactly one cycle per granted result.
- Latency:
  - Accept at edge E0, broadcast visible after E1: minimum 2 cycles.
  - One result per cycle maximum throughput.
- pending_cnt = popcount(buf_valid), registered alongside the buffers.
- Squash:
  - At a squash edge, all buf_valid bits and cdb_valid clear and no new accepts occur.
  - The pointer is not reset.
  - Squash has priority over a simultaneous grant and a simultaneous accept.
- Boundaries:
  - All buffers full, no squash: exactly one grant per cycle, and only the granted index shows ready.
  - Single requester: back-to-back results stream at 1/cycle.
  - Reset mid-transfer: payloads are discarded and no CDB pulse is emitted.

Optional Feature:
- Macro: CDB_AGE_PRIORITY_EN.
- Defined:
  - Winner is the occupied buffer with the smallest age, where age = (tag - rob_head) mod 2^TAG_W.
  - Ties go to the lowest index.
  - The pointer is unused but still maintained.
- Undefined:
  - Pure round-robin as above.
  - The rob_head input is ignored.

Test Plan:
- Reset, then req_valid=0001 with tag=3, value=0xAA, pc=0x100 at cycle 1 -> cdb_valid=1, tag=3, value=0xAA, src=0 in cycle 3 only; pending_cnt reads 1 in cycle 2 and 0 in cycle 3.
- All four units request every cycle, pointer=0 -> cdb_src sequence 0,1,2,3,0; each unit's req_ready high once per 4 cycles.
- Buffers 1 and 3 full, squash pulsed -> next cycle cdb_valid=0 and pending_cnt=0; no broadcast of either tag.
- Unit 2 streams tags 4,5,6,7 on consecutive cycles, others idle -> CDB carries 4,5,6,7 on consecutive cycles, no bubbles.
- CDB_AGE_PRIORITY_EN, rob_head=30, buffers hold tags 1 (unit 0) and 31 (unit 3) -> unit 3 wins first (age 1 vs 3), then unit 0.
- Async reset asserted mid-cycle with 3 buffers full -> outputs clear immediately, no cdb_valid pulse after deassert.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding buffer per completing unit, one
// registered CDB broadcast per cycle. Define CDB_AGE_PRIORITY_EN for oldest-first arbitration.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned DATA_W  = 32,
  localparam int unsigned SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CNT_W  = $clog2(NUM_REQ) + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        squash,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]   req_value,
  input  logic [NUM_REQ*DATA_W-1:0]   req_pc,
  input  logic [NUM_REQ-1:0]          req_take_branch,
  input  logic [TAG_W-1:0]            rob_head,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_value,
  output logic [DATA_W-1:0]           cdb_pc,
  output logic                        cdb_take_branch,
  output logic [SRC_W-1:0]            cdb_src,
  output logic [CNT_W-1:0]            pending_cnt
);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] pc;
    logic              take_branch;
  } payload_t;

  payload_t             req_pl    [NUM_REQ];
  payload_t             buf_q     [NUM_REQ];
  logic [NUM_REQ-1:0]   buf_valid;
  logic [SRC_W-1:0]     rr_ptr;

  logic                 found;
  logic [SRC_W-1:0]     winner;
  logic                 grant_any;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   accept;
  logic [NUM_REQ-1:0]   buf_valid_nxt;
  logic [CNT_W-1:0]     pending_nxt;
  logic [SRC_W-1:0]     rr_ptr_nxt;

  // Unpack the flat per-unit request buses
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_pl[i].tag         = req_tag[i*TAG_W +: TAG_W];
      req_pl[i].value       = req_value[i*DATA_W +: DATA_W];
      req_pl[i].pc          = req_pc[i*DATA_W +: DATA_W];
      req_pl[i].take_branch = req_take_branch[i];
    end
  end

`ifdef CDB_AGE_PRIORITY_EN
  logic [TAG_W-1:0] best_age;
  logic [TAG_W-1:0] cur_age;

  // Oldest result relative to the ROB head wins; strict compare keeps ties at the lowest index
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    best_age = '0;
    cur_age  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cur_age = buf_q[i].tag - rob_head;
      if (buf_valid[i] && (!found || (cur_age < best_age))) begin
        found    = 1'b1;
        winner   = SRC_W'(i);
        best_age = cur_age;
      end
    end
  end
`else
  int unsigned rr_idx;
  logic        unused_rob_head;

  assign unused_rob_head = ^rob_head;

  // Round-robin search over occupied buffers starting at the pointer
  always_comb begin
    found  = 1'b0;
    winner = '0;
    rr_idx = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rr_idx = 32'(rr_ptr) + k;
      if (rr_idx >= NUM_REQ) begin
        rr_idx = rr_idx - NUM_REQ;
      end
      if (!found && buf_valid[rr_idx]) begin
        found  = 1'b1;
        winner = SRC_W'(rr_idx);
      end
    end
  end
`endif

  // Squash suppresses the grant so nothing reaches the CDB on a flush edge
  always_comb begin
    grant     = '0;
    grant_any = found && !squash;
    if (grant_any) begin
      grant[winner] = 1'b1;
    end
  end

  assign req_ready = squash ? '0 : (~buf_valid | grant);
  assign accept    = req_valid & req_ready;

  always_comb begin
    buf_valid_nxt = squash ? '0 : ((buf_valid & ~grant) | accept);
    pending_nxt   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pending_nxt = pending_nxt + CNT_W'(buf_valid_nxt[i]);
    end
  end

  assign rr_ptr_nxt = (32'(winner) == NUM_REQ - 1) ? '0 : SRC_W'(winner + 1'b1);

  // Payload storage carries no reset; occupancy is tracked by buf_valid
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        buf_q[i] <= req_pl[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_valid       <= '0;
      pending_cnt     <= '0;
      rr_ptr          <= '0;
      cdb_valid       <= 1'b0;
      cdb_tag         <= '0;
      cdb_value       <= '0;
      cdb_pc          <= '0;
      cdb_take_branch <= 1'b0;
      cdb_src         <= '0;
    end else begin
      buf_valid   <= buf_valid_nxt;
      pending_cnt <= pending_nxt;
      cdb_valid   <= grant_any;
      if (grant_any) begin
        cdb_tag         <= buf_q[winner].tag;
        cdb_value       <= buf_q[winner].value;
        cdb_pc          <= buf_q[winner].pc;
        cdb_take_branch <= buf_q[winner].take_branch;
        cdb_src         <= winner;
        rr_ptr          <= rr_ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts are queued at stimulus time
// and matched by a monitor whenever the CDB fires.
module tb_cdb_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned TAG_W   = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SRC_W   = 2;
  localparam int unsigned CNT_W   = 3;

  logic                        clock;
  logic                        reset;
  logic                        squash;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*TAG_W-1:0]    req_tag;
  logic [NUM_REQ*DATA_W-1:0]   req_value;
  logic [NUM_REQ*DATA_W-1:0]   req_pc;
  logic [NUM_REQ-1:0]          req_take_branch;
  logic [TAG_W-1:0]            rob_head;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        cdb_valid;
  logic [TAG_W-1:0]            cdb_tag;
  logic [DATA_W-1:0]           cdb_value;
  logic [DATA_W-1:0]           cdb_pc;
  logic                        cdb_take_branch;
  logic [SRC_W-1:0]            cdb_src;
  logic [CNT_W-1:0]            pending_cnt;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] pc;
    logic              take;
    logic [SRC_W-1:0]  src;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;
  int   kcnt [NUM_REQ];

  cdb_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .squash          (squash),
    .req_valid       (req_valid),
    .req_tag         (req_tag),
    .req_value       (req_value),
    .req_pc          (req_pc),
    .req_take_branch (req_take_branch),
    .rob_head        (rob_head),
    .req_ready       (req_ready),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .cdb_value       (cdb_value),
    .cdb_pc          (cdb_pc),
    .cdb_take_branch (cdb_take_branch),
    .cdb_src         (cdb_src),
    .pending_cnt     (pending_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
  endtask

  task automatic set_unit(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v,
                          input logic [DATA_W-1:0] p, input logic tk);
    req_tag[i*TAG_W +: TAG_W]    = t;
    req_value[i*DATA_W +: DATA_W] = v;
    req_pc[i*DATA_W +: DATA_W]    = p;
    req_take_branch[i]            = tk;
  endtask

  task automatic push_exp(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v,
                          input logic [DATA_W-1:0] p, input logic tk, input logic [SRC_W-1:0] s);
    exp_t e;
    e.tag = t; e.value = v; e.pc = p; e.take = tk; e.src = s;
    sb.push_back(e);
  endtask

  // Payload generator for the all-units stream: unit i, k-th result
  function automatic logic [TAG_W-1:0] g_tag(input int i, input int k);
    return TAG_W'(i*8 + k);
  endfunction
  function automatic logic [DATA_W-1:0] g_val(input int i, input int k);
    return DATA_W'(32'hA000_0000 + i*256 + k);
  endfunction
  function automatic logic [DATA_W-1:0] g_pc(input int i, input int k);
    return DATA_W'(32'h1000 + i*256 + k*4);
  endfunction
  function automatic logic g_tk(input int i, input int k);
    return 1'((i + k) % 2);
  endfunction

  task automatic do_reset();
    req_valid = '0;
    squash    = 1'b0;
    #2 reset  = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Monitor: every CDB pulse must match the oldest queued expectation
  always @(negedge clock) begin
    if (!reset && cdb_valid) begin
      if (sb.size() == 0) begin
        check("cdb_unexpected", 64'(cdb_valid), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        check("cdb_tag",   64'(cdb_tag),         64'(mon_e.tag));
        check("cdb_value", 64'(cdb_value),       64'(mon_e.value));
        check("cdb_pc",    64'(cdb_pc),          64'(mon_e.pc));
        check("cdb_take",  64'(cdb_take_branch), 64'(mon_e.take));
        check("cdb_src",   64'(cdb_src),         64'(mon_e.src));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_REQ-1:0] rdy;
    reset           = 1'b1;
    squash          = 1'b0;
    req_valid       = '0;
    req_tag         = '0;
    req_value       = '0;
    req_pc          = '0;
    req_take_branch = '0;
    rob_head        = '0;

    // Reset state
    @(posedge clock); #1;
    check("rst_cdb_valid", 64'(cdb_valid),   64'(0));
    check("rst_pending",   64'(pending_cnt), 64'(0));
    check("rst_cdb_tag",   64'(cdb_tag),     64'(0));
    check("rst_cdb_src",   64'(cdb_src),     64'(0));
    @(negedge clock);
    reset = 1'b0;
    #1 check("rst_ready", 64'(req_ready), 64'hF);

    // Single result, 2-cycle latency
    set_unit(0, 5'd3, 32'hAA, 32'h100, 1'b0);
    req_valid = 4'b0001;
    push_exp(5'd3, 32'hAA, 32'h100, 1'b0, 2'd0);
    @(posedge clock); #1;
    req_valid = '0;
    check("t1_pending_c2", 64'(pending_cnt), 64'(1));
    check("t1_valid_c2",   64'(cdb_valid),   64'(0));
    @(posedge clock); #1;
    check("t1_pending_c3", 64'(pending_cnt), 64'(0));
    check("t1_valid_c3",   64'(cdb_valid),   64'(1));
    @(posedge clock); #1;
    check("t1_valid_c4",   64'(cdb_valid),   64'(0));
    check("t1_sb_empty",   64'(sb.size()),   64'(0));

    // All four units request every cycle from pointer 0
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      kcnt[i] = 0;
      set_unit(i, g_tag(i, 0), g_val(i, 0), g_pc(i, 0), g_tk(i, 0));
    end
    for (int n = 0; n < 11; n++) begin
      push_exp(g_tag(n % 4, n / 4), g_val(n % 4, n / 4), g_pc(n % 4, n / 4), g_tk(n % 4, n / 4), SRC_W'(n % 4));
    end
    req_valid = 4'b1111;
    for (int e = 1; e <= 8; e++) begin
      #1 rdy = req_ready;
      @(posedge clock); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rdy[i]) begin
          kcnt[i]++;
          set_unit(i, g_tag(i, kcnt[i]), g_val(i, kcnt[i]), g_pc(i, kcnt[i]), g_tk(i, kcnt[i]));
        end
      end
      check("t2_ready_onehot", 64'(req_ready),   64'(4'b0001 << ((e - 1) % 4)));
      check("t2_pending_full", 64'(pending_cnt), 64'(4));
    end
    req_valid = '0;
    repeat (6) @(posedge clock);
    #1;
    check("t2_sb_empty",  64'(sb.size()),   64'(0));
    check("t2_pending_0", 64'(pending_cnt), 64'(0));

    // Squash with buffers 1 and 3 full, plus a competing request during squash
    set_unit(1, 5'd9,  32'h9, 32'h900, 1'b1);
    set_unit(3, 5'd27, 32'h27, 32'h2700, 1'b0);
    req_valid = 4'b1010;
    @(posedge clock); #1;
    check("t3_pending_2", 64'(pending_cnt), 64'(2));
    set_unit(2, 5'd20, 32'h20, 32'h2000, 1'b0);
    req_valid = 4'b0100;
    squash    = 1'b1;
    #1 check("t3_ready_squash", 64'(req_ready), 64'(0));
    @(posedge clock); #1;
    squash    = 1'b0;
    req_valid = '0;
    check("t3_cdb_valid", 64'(cdb_valid),   64'(0));
    check("t3_pending_0", 64'(pending_cnt), 64'(0));
    repeat (4) @(posedge clock);
    #1 check("t3_sb_empty", 64'(sb.size()), 64'(0));

    // Unit 2 streams back-to-back
    for (int k = 0; k < 4; k++) begin
      set_unit(2, TAG_W'(4 + k), DATA_W'(32'h400 + k), DATA_W'(32'h2000 + 4*k), 1'(k == 2));
      push_exp(TAG_W'(4 + k), DATA_W'(32'h400 + k), DATA_W'(32'h2000 + 4*k), 1'(k == 2), 2'd2);
      req_valid = 4'b0100;
      #1 check("t4_ready2", 64'(req_ready[2]), 64'(1));
      @(posedge clock); #1;
      if (k > 0) check("t4_stream_valid", 64'(cdb_valid), 64'(1));
    end
    req_valid = '0;
    @(posedge clock); #1;
    check("t4_stream_last", 64'(cdb_valid), 64'(1));
    @(posedge clock); #1;
    check("t4_stream_end",  64'(cdb_valid), 64'(0));
    check("t4_sb_empty",    64'(sb.size()), 64'(0));

    // Priority between tag 1 (unit 0) and tag 31 (unit 3) with rob_head 30
    do_reset();
    rob_head = 5'd30;
    set_unit(0, 5'd1,  32'h11, 32'h200, 1'b0);
    set_unit(3, 5'd31, 32'h33, 32'h300, 1'b1);
`ifdef CDB_AGE_PRIORITY_EN
    push_exp(5'd31, 32'h33, 32'h300, 1'b1, 2'd3);
    push_exp(5'd1,  32'h11, 32'h200, 1'b0, 2'd0);
`else
    push_exp(5'd1,  32'h11, 32'h200, 1'b0, 2'd0);
    push_exp(5'd31, 32'h33, 32'h300, 1'b1, 2'd3);
`endif
    req_valid = 4'b1001;
    @(posedge clock); #1;
    req_valid = '0;
    repeat (4) @(posedge clock);
    #1 check("t5_sb_empty", 64'(sb.size()), 64'(0));

    // Async reset mid-cycle with three buffers full
    for (int i = 0; i < 3; i++) set_unit(i, TAG_W'(10 + i), DATA_W'(32'h77 + i), DATA_W'(32'h700 + i), 1'b1);
    req_valid = 4'b0111;
    @(posedge clock); #1;
    req_valid = '0;
    check("t6_pending_3", 64'(pending_cnt), 64'(3));
    #2 reset = 1'b1;
    #1;
    check("t6_async_pending", 64'(pending_cnt), 64'(0));
    check("t6_async_tag",     64'(cdb_tag),     64'(0));
    check("t6_async_src",     64'(cdb_src),     64'(0));
    check("t6_async_valid",   64'(cdb_valid),   64'(0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1 check("t6_ready_all", 64'(req_ready), 64'hF);
    repeat (5) @(posedge clock);
    #1;
    check("t6_pending_0", 64'(pending_cnt), 64'(0));
    check("t6_sb_empty",  64'(sb.size()),   64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
